iadder_b16_8a_recover: RTL and testbench

Sequential error-recovery unit for the 16-bit split-carry approximate adder (8-bit low/high halves, high half fed with A[0] as speculative carry). It takes the operands plus the approximate sum, recomputes the true carry out of the low byte, and either passes the sum through or applies a ±256 correction in one extra cycle. It also flags and counts speculation errors. It sits after the approximate adder on paths that need exact results, with valid/ready handshakes on both sides.

---
 rtl/iadder_b16_8a_recover_pkg.sv | 15 +
 rtl/iadder_b16_8a_errcnt.sv | 24 ++
 rtl/iadder_b16_8a_recover.sv | 105 ++++++++++
 tb/tb_iadder_b16_8a_recover.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/iadder_b16_8a_recover_pkg.sv
// Shared types and constants for the split-carry adder recovery unit.
package iadder_b16_8a_recover_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int unsigned LO_W   = 8;
    localparam int unsigned HI_OFS = 8;
    localparam logic [15:0] CORR   = 16'h0100;

endpackage

// File: rtl/iadder_b16_8a_errcnt.sv
// Saturating error counter; a synchronous clear takes priority over an increment.
module iadder_b16_8a_errcnt
    import iadder_b16_8a_recover_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iadder_b16_8a_recover.sv
// Error-recovery stage for the 16-bit split-carry adder: checks the speculative
// carry into the high byte and applies a +/-256 fix-up when it was wrong.
module iadder_b16_8a_recover
    import iadder_b16_8a_recover_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [15:0]      sum_apx,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      sum,
    output logic             err,
    output logic             err_dir,
    output logic             bad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_cnt
);

    state_t          state;
    logic [LO_W-1:0] a_lo;
    logic [LO_W-1:0] b_lo;
    logic [15:0]     apx;
    logic [LO_W:0]   lo_sum;
    logic            c8;
    logic            spec;
    logic            mis;

    // Only the low bytes matter: the high halves are already folded into sum_apx.
    logic unused;
    assign unused = ^{a[15:LO_W], b[15:LO_W]};

    assign lo_sum   = {1'b0, a_lo} + {1'b0, b_lo};
    assign c8       = lo_sum[LO_W];
    assign spec     = a_lo[0];
    assign mis      = (state == EVAL) && (c8 != spec);
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_lo      <= '0;
            b_lo      <= '0;
            apx       <= '0;
            sum       <= '0;
            err       <= 1'b0;
            err_dir   <= 1'b0;
            bad       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lo  <= a[LO_W-1:0];
                        b_lo  <= b[LO_W-1:0];
                        apx   <= sum_apx;
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    bad <= (apx[HI_OFS-1:0] != lo_sum[LO_W-1:0]);
                    if (c8 == spec) begin
                        sum       <= apx;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        err     <= 1'b1;
                        err_dir <= c8;
                        state   <= FIX;
                    end
                end
                FIX: begin
                    // Low byte is left as given even when it was inconsistent.
                    sum       <= err_dir ? (apx + CORR) : (apx - CORR);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    iadder_b16_8a_errcnt #(
        .CNT_W (CNT_W)
    ) u_errcnt (
        .clk (clk),
        .rst (rst),
        .inc (mis),
        .clr (clr_cnt),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_iadder_b16_8a_recover.sv
// Scoreboard bench for iadder_b16_8a_recover with a 2-bit error counter.
module tb_iadder_b16_8a_recover;

    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      a, b, sum_apx;
    logic             in_valid, in_ready;
    logic [15:0]      sum;
    logic             err, err_dir, bad, out_valid, out_ready, clr_cnt;
    logic [CNT_W-1:0] err_cnt;

    typedef struct {
        logic [15:0]      sum;
        logic             err;
        logic             dir;
        logic             bad;
        int               lat;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] cnt_model;
    int               n_checks = 0;
    int               n_pass = 0;

    iadder_b16_8a_recover #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .sum_apx   (sum_apx),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .err       (err),
        .err_dir   (err_dir),
        .bad       (bad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                   input logic [15:0] apx, input logic clr);
        exp_t e;
        logic [8:0] lo;
        logic c8;
        lo    = {1'b0, ta[7:0]} + {1'b0, tb_[7:0]};
        c8    = lo[8];
        e.err = (c8 != ta[0]);
        e.dir = c8;
        e.bad = (apx[7:0] != lo[7:0]);
        e.sum = !e.err ? apx : (c8 ? apx + 16'h0100 : apx - 16'h0100);
        e.lat = e.err ? 2 : 1;
        if (clr) cnt_model = '0;
        else if (e.err && cnt_model != {CNT_W{1'b1}}) cnt_model = cnt_model + 1'b1;
        e.cnt = cnt_model;
        return e;
    endfunction

    function automatic logic [15:0] approx(input logic [15:0] ta, input logic [15:0] tb_);
        logic [7:0] hi, lo;
        lo = ta[7:0] + tb_[7:0];
        hi = ta[15:8] + tb_[15:8] + {7'd0, ta[0]};
        return {hi, lo};
    endfunction

    // Called at posedge+1 with the DUT idle.
    task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [15:0] apx, input int hold, input logic clr);
        exp_t e;
        int   cycles;
        logic [15:0] held;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a = ta; b = tb_; sum_apx = apx; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr_cnt  = clr;
        sb.push_back(model(ta, tb_, apx, clr));
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        cycles  = 1;
        while (!out_valid && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
        end
        e = sb.pop_front();
        check("latency", 32'(cycles), 32'(e.lat));
        check("sum", 32'(sum), 32'(e.sum));
        check("err", 32'(err), 32'(e.err));
        if (e.err) check("err_dir", 32'(err_dir), 32'(e.dir));
        check("bad", 32'(bad), 32'(e.bad));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        held = sum;
        in_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_sum", 32'(sum), 32'(held));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst = 1'b1; a = '0; b = '0; sum_apx = '0;
        in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        cnt_model = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn(16'h1234, 16'h4321, 16'h5555, 0, 1'b0);
        do_txn(16'h0080, 16'h0080, 16'h0000, 0, 1'b0);
        do_txn(16'h0001, 16'h0000, 16'h0101, 0, 1'b0);
        do_txn(16'h00FF, 16'h0001, 16'h0100, 0, 1'b0);
        do_txn(16'h00FF, 16'h0001, 16'h01FF, 5, 1'b0);
        do_txn(16'h0080, 16'h0080, 16'h0000, 0, 1'b0);
        do_txn(16'h0001, 16'h0000, 16'h0101, 1, 1'b0);
        do_txn(16'h0001, 16'h0002, 16'h0103, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_txn(ra, rb, approx(ra, rb), i % 3, 1'b0);
        end

        // Reset while the unit sits in FIX.
        a = 16'h0080; b = 16'h0080; sum_apx = 16'h0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("fix_no_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_dir", 32'(err_dir), 32'd0);
        check("midrst_bad", 32'(bad), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cnt", 32'(err_cnt), 32'd0);
        cnt_model = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        check("midrst_dropped", 32'(out_valid), 32'd0);
        do_txn(16'h0080, 16'h0080, 16'h0000, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
